// File: rtl/mem_port_arbiter_if.sv
// Bundle of CPU-side request/response and RAM-side signals around the memory port arbiter.
// The arbiter uses the slave modport; the CPU core/RAM environment uses master.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_valid;
  logic              d_rd;
  logic              d_wr;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_valid;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;
  logic              proto_err;

  modport slave (
    input  if_req, if_addr, d_rd, d_wr, d_addr, d_wdata, mem_rdata,
    output if_rdata, if_valid, d_rdata, d_valid,
           mem_en, mem_we, mem_addr, mem_wdata, busy, proto_err
  );

  modport master (
    output if_req, if_addr, d_rd, d_wr, d_addr, d_wdata, mem_rdata,
    input  if_rdata, if_valid, d_rdata, d_valid,
           mem_en, mem_we, mem_addr, mem_wdata, busy, proto_err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous RAM between instruction fetch and load/store.
// Data has priority; a saturating starve counter forces fetch through after STARVE_LIMIT data grants.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W       = 12,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic               clk,
  input  logic               reset,
  mem_port_arbiter_if.slave  bus
);

  localparam int unsigned          CNT_W = 4;
  localparam logic [CNT_W-1:0]     LIMIT = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                data_own_q, data_own_d;
  logic                wr_op_q, wr_op_d;
  logic [CNT_W-1:0]    starve_q, starve_d;
  logic                proto_q, proto_d;
  logic                mem_en_q, mem_en_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
  logic                if_valid_q, if_valid_d;
  logic                d_valid_q, d_valid_d;
  logic                busy_q, busy_d;

  logic                starved;
  logic                gnt_d;
  logic                gnt_f;

  // Grant selection, only acted on in IDLE
  always_comb begin
    starved = bus.if_req && (starve_q == LIMIT);
    gnt_d   = !starved && (bus.d_rd || bus.d_wr);
    gnt_f   = bus.if_req && !gnt_d;
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      data_own_q  <= 1'b0;
      wr_op_q     <= 1'b0;
      starve_q    <= '0;
      proto_q     <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_valid_q  <= 1'b0;
      d_valid_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_own_q  <= data_own_d;
      wr_op_q     <= wr_op_d;
      starve_q    <= starve_d;
      proto_q     <= proto_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      if_valid_q  <= if_valid_d;
      d_valid_q   <= d_valid_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (gnt_d || gnt_f) state_d = ISSUE;
      ISSUE:   state_d = wr_op_q ? DONE : WAIT;
      WAIT:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs and bookkeeping
  always_comb begin
    data_own_d  = data_own_q;
    wr_op_d     = wr_op_q;
    starve_d    = starve_q;
    proto_d     = proto_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_valid_d  = 1'b0;
    d_valid_d   = 1'b0;
    busy_d      = (state_d != IDLE);

    case (state_q)
      IDLE: begin
        if (!bus.if_req || gnt_f) begin
          starve_d = '0;
        end else if (starve_q != LIMIT) begin
          starve_d = starve_q + CNT_W'(1);
        end
        if (gnt_d || gnt_f) begin
          mem_en_d   = 1'b1;
          mem_we_d   = gnt_d && bus.d_wr;
          mem_addr_d = gnt_d ? bus.d_addr : bus.if_addr;
          data_own_d = gnt_d;
          wr_op_d    = gnt_d && bus.d_wr;
          if (gnt_d) mem_wdata_d = bus.d_wdata;
          if (gnt_d && bus.d_rd && bus.d_wr) proto_d = 1'b1;
        end
      end
      ISSUE: begin
        if (wr_op_q) d_valid_d = 1'b1;
      end
      WAIT: begin
        if (data_own_q) begin
          d_rdata_d = bus.mem_rdata;
          d_valid_d = 1'b1;
        end else begin
          if_rdata_d = bus.mem_rdata;
          if_valid_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.if_valid  = if_valid_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.d_valid   = d_valid_q;
  assign bus.busy      = busy_q;
  assign bus.proto_err = proto_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboarded bench for mem_port_arbiter: directed latency/priority cases plus randomized traffic.
// Expected read data comes from a reference memory image kept in order of issued requests.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(12), .DATA_W(32)) bus ();

  mem_port_arbiter #(.ADDR_W(12), .DATA_W(32), .STARVE_LIMIT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Environment RAM with a backdoor load port
  logic [31:0] ram [0:4095];
  logic [31:0] ram_rd;
  logic        bk_we;
  logic [11:0] bk_addr;
  logic [31:0] bk_data;

  always @(posedge clk) begin
    if (bk_we) ram[bk_addr] <= bk_data;
    else if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      else            ram_rd <= ram[bus.mem_addr];
    end
  end
  assign bus.mem_rdata = ram_rd;

  typedef struct {
    logic        chk;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_if_q[$];
  exp_t        exp_d_q[$];
  logic [31:0] ref_mem [0:4095];
  int          n_vec = 0;
  int          n_err = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endfunction

  function automatic void chk1(string name, logic act, logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endfunction

  function automatic void fail_now(string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: event did not occur as required", name);
  endfunction

  // Monitor: every valid pulse must match the oldest outstanding expectation
  exp_t mon_e;
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (bus.if_valid === 1'b1) begin
        if (exp_if_q.size() == 0) fail_now("if_valid_unexpected");
        else begin
          mon_e = exp_if_q.pop_front();
          if (mon_e.chk) chk("if_rdata", bus.if_rdata, mon_e.data);
        end
      end
      if (bus.d_valid === 1'b1) begin
        if (exp_d_q.size() == 0) fail_now("d_valid_unexpected");
        else begin
          mon_e = exp_d_q.pop_front();
          if (mon_e.chk) chk("d_rdata", bus.d_rdata, mon_e.data);
        end
      end
    end
  end

  task automatic backdoor(input logic [11:0] a, input logic [31:0] d);
    bk_addr = a;
    bk_data = d;
    bk_we   = 1'b1;
    ref_mem[a] = d;
    @(negedge clk);
    bk_we = 1'b0;
  endtask

  task automatic wait_valid(input bit is_fetch);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (is_fetch ? (bus.if_valid === 1'b1) : (bus.d_valid === 1'b1)) return;
    end
    fail_now(is_fetch ? "if_valid_timeout" : "d_valid_timeout");
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 50; i++) begin
      if (bus.busy === 1'b0) return;
      @(negedge clk);
    end
    fail_now("idle_timeout");
  endtask

  task automatic push_if(input logic [11:0] a);
    exp_t e;
    e.chk  = 1'b1;
    e.data = ref_mem[a];
    exp_if_q.push_back(e);
  endtask

  task automatic push_d(input bit wr, input logic [11:0] a, input logic [31:0] wd);
    exp_t e;
    if (wr) begin
      ref_mem[a] = wd;
      e.chk  = 1'b0;
      e.data = '0;
    end else begin
      e.chk  = 1'b1;
      e.data = ref_mem[a];
    end
    exp_d_q.push_back(e);
  endtask

  task automatic fetch_op(input logic [11:0] a);
    bus.if_addr = a;
    bus.if_req  = 1'b1;
    push_if(a);
    wait_valid(1'b1);
    bus.if_req = 1'b0;
  endtask

  task automatic data_op(input bit wr, input logic [11:0] a, input logic [31:0] wd);
    bus.d_addr  = a;
    bus.d_wdata = wd;
    bus.d_rd    = !wr;
    bus.d_wr    = wr;
    push_d(wr, a, wd);
    wait_valid(1'b0);
    bus.d_rd = 1'b0;
    bus.d_wr = 1'b0;
  endtask

  // Fetch held while data re-requests after every completion; counts data wins before fetch
  task automatic starve_run(input string name);
    logic [11:0] a;
    int          nd;
    bit          got_f;
    wait_idle();
    bus.if_addr = 12'h804;
    bus.if_req  = 1'b1;
    push_if(12'h804);
    a = 12'($urandom_range(0, 255));
    bus.d_addr = a;
    bus.d_rd   = 1'b1;
    push_d(1'b0, a, '0);
    nd    = 0;
    got_f = 1'b0;
    for (int i = 0; i < 100 && !got_f; i++) begin
      @(negedge clk);
      if (bus.if_valid === 1'b1) begin
        got_f      = 1'b1;
        bus.if_req = 1'b0;
      end else if (bus.d_valid === 1'b1) begin
        nd++;
        a = 12'($urandom_range(0, 255));
        bus.d_addr = a;
        push_d(1'b0, a, '0);
      end
    end
    if (!got_f) fail_now({name, "_fetch_timeout"});
    chk(name, 32'(nd), 32'd4);
    wait_valid(1'b0);
    bus.d_rd = 1'b0;
  endtask

  logic [31:0] x004;

  initial begin
    reset       = 1'b1;
    bk_we       = 1'b0;
    bk_addr     = '0;
    bk_data     = '0;
    bus.if_req  = 1'b0;
    bus.if_addr = '0;
    bus.d_rd    = 1'b0;
    bus.d_wr    = 1'b0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;
    @(negedge clk);
    for (int i = 0; i < 256; i++) begin
      backdoor(12'(i), $urandom);
      backdoor(12'(12'h800 + i), $urandom);
    end

    // Reset with random inputs on the request side
    repeat (2) begin
      bus.if_req  = 1'($urandom_range(0, 1));
      bus.if_addr = 12'($urandom);
      bus.d_rd    = 1'($urandom_range(0, 1));
      bus.d_wr    = 1'($urandom_range(0, 1));
      bus.d_addr  = 12'($urandom);
      bus.d_wdata = $urandom;
      @(negedge clk);
    end
    chk ("rst_if_rdata",  bus.if_rdata, 32'h0);
    chk ("rst_d_rdata",   bus.d_rdata, 32'h0);
    chk1("rst_if_valid",  bus.if_valid, 1'b0);
    chk1("rst_d_valid",   bus.d_valid, 1'b0);
    chk1("rst_mem_en",    bus.mem_en, 1'b0);
    chk1("rst_mem_we",    bus.mem_we, 1'b0);
    chk ("rst_mem_addr",  32'(bus.mem_addr), 32'h0);
    chk ("rst_mem_wdata", bus.mem_wdata, 32'h0);
    chk1("rst_busy",      bus.busy, 1'b0);
    chk1("rst_proto",     bus.proto_err, 1'b0);
    reset       = 1'b0;
    bus.if_req  = 1'b0;
    bus.d_rd    = 1'b0;
    bus.d_wr    = 1'b0;
    @(negedge clk);
    chk1("idle_busy",   bus.busy, 1'b0);
    chk1("idle_mem_en", bus.mem_en, 1'b0);

    // Fetch read latency
    backdoor(12'h010, 32'hDEADBEEF);
    wait_idle();
    bus.if_addr = 12'h010;
    bus.if_req  = 1'b1;
    push_if(12'h010);
    @(negedge clk);
    chk1("fetch_mem_en",   bus.mem_en, 1'b1);
    chk1("fetch_mem_we",   bus.mem_we, 1'b0);
    chk ("fetch_mem_addr", 32'(bus.mem_addr), 32'h010);
    @(negedge clk);
    chk1("fetch_en_drop",  bus.mem_en, 1'b0);
    chk1("fetch_early",    bus.if_valid, 1'b0);
    @(negedge clk);
    chk1("fetch_valid",    bus.if_valid, 1'b1);
    chk ("fetch_rdata",    bus.if_rdata, 32'hDEADBEEF);
    bus.if_req = 1'b0;
    @(negedge clk);
    chk1("fetch_pulse",    bus.if_valid, 1'b0);
    chk1("fetch_busy_end", bus.busy, 1'b0);
    chk ("fetch_hold",     bus.if_rdata, 32'hDEADBEEF);

    // Contention: data first, fetch on the following decision
    backdoor(12'h100, 32'h0000CAFE);
    x004 = $urandom;
    backdoor(12'h004, x004);
    wait_idle();
    bus.if_addr = 12'h004;
    bus.if_req  = 1'b1;
    bus.d_addr  = 12'h100;
    bus.d_rd    = 1'b1;
    push_d(1'b0, 12'h100, '0);
    push_if(12'h004);
    @(negedge clk);
    chk("cont_d_addr", 32'(bus.mem_addr), 32'h100);
    repeat (2) @(negedge clk);
    chk1("cont_d_valid", bus.d_valid, 1'b1);
    chk ("cont_d_rdata", bus.d_rdata, 32'h0000CAFE);
    bus.d_rd = 1'b0;
    @(negedge clk);
    chk1("cont_idle", bus.busy, 1'b0);
    @(negedge clk);
    chk1("cont_f_en",   bus.mem_en, 1'b1);
    chk ("cont_f_addr", 32'(bus.mem_addr), 32'h004);
    repeat (2) @(negedge clk);
    chk1("cont_if_valid", bus.if_valid, 1'b1);
    chk ("cont_if_rdata", bus.if_rdata, x004);
    bus.if_req = 1'b0;

    // Store then load
    @(negedge clk);
    wait_idle();
    bus.d_addr  = 12'h020;
    bus.d_wdata = 32'h12345678;
    bus.d_wr    = 1'b1;
    push_d(1'b1, 12'h020, 32'h12345678);
    @(negedge clk);
    chk1("st_mem_en",    bus.mem_en, 1'b1);
    chk1("st_mem_we",    bus.mem_we, 1'b1);
    chk ("st_mem_addr",  32'(bus.mem_addr), 32'h020);
    chk ("st_mem_wdata", bus.mem_wdata, 32'h12345678);
    @(negedge clk);
    chk1("st_d_valid",   bus.d_valid, 1'b1);
    chk1("st_en_drop",   bus.mem_en, 1'b0);
    chk1("st_we_drop",   bus.mem_we, 1'b0);
    bus.d_wr = 1'b0;
    @(negedge clk);
    wait_idle();
    data_op(1'b0, 12'h020, '0);
    chk("ld_after_st", bus.d_rdata, 32'h12345678);

    // Starvation guard, twice to show the counter clears after the fetch win
    starve_run("starve_grants_1");
    starve_run("starve_grants_2");

    // Simultaneous read and write: write wins, error is sticky
    @(negedge clk);
    wait_idle();
    bus.d_addr  = 12'h030;
    bus.d_wdata = 32'hA5A55A5A;
    bus.d_rd    = 1'b1;
    bus.d_wr    = 1'b1;
    push_d(1'b1, 12'h030, 32'hA5A55A5A);
    @(negedge clk);
    chk1("proto_mem_we", bus.mem_we, 1'b1);
    wait_valid(1'b0);
    bus.d_rd = 1'b0;
    bus.d_wr = 1'b0;
    chk1("proto_set", bus.proto_err, 1'b1);
    @(negedge clk);
    wait_idle();
    data_op(1'b0, 12'h030, '0);
    chk("proto_wr_done", bus.d_rdata, 32'hA5A55A5A);

    // Randomized concurrent traffic; fetch reads a region data never writes
    @(negedge clk);
    fork
      begin
        for (int k = 0; k < 40; k++) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          fetch_op(12'h800 | 12'($urandom_range(0, 255)));
        end
      end
      begin
        for (int k = 0; k < 40; k++) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          data_op(1'($urandom_range(0, 1)), 12'($urandom_range(0, 255)), $urandom);
        end
      end
    join
    @(negedge clk);
    wait_idle();
    chk1("proto_sticky", bus.proto_err, 1'b1);
    chk("sb_if_empty", 32'(exp_if_q.size()), 32'd0);
    chk("sb_d_empty",  32'(exp_d_q.size()), 32'd0);

    // Reset while a read sits in WAIT
    bus.d_addr = 12'h040;
    bus.d_rd   = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk1("abort_in_wait", bus.busy, 1'b1);
    reset    = 1'b1;
    bus.d_rd = 1'b0;
    @(negedge clk);
    chk1("abort_if_valid", bus.if_valid, 1'b0);
    chk1("abort_d_valid",  bus.d_valid, 1'b0);
    chk1("abort_busy",     bus.busy, 1'b0);
    chk1("abort_mem_en",   bus.mem_en, 1'b0);
    chk1("abort_proto",    bus.proto_err, 1'b0);
    chk ("abort_d_rdata",  bus.d_rdata, 32'h0);
    reset = 1'b0;
    @(negedge clk);
    chk1("abort_no_valid", bus.d_valid, 1'b0);
    chk1("abort_idle",     bus.busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous RAM between the instruction-fetch requester (PC side) and the load/store requester (`mem_rd`/`mem_wr` side) of the micro CPU.
- Sits between the CPU core and the unified RAM.
- Sequences each access through a small FSM and returns read data with a one-cycle valid pulse.
- Data accesses have priority; a starvation guard guarantees forward progress for fetch.

Parameters:
- ADDR_W, 12, RAM word-address width.
- DATA_W, 32, data word width.
- STARVE_LIMIT, 4, number of consecutive data grants a waiting fetch tolerates before it is forced to win (range 1..15).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- if_req  in  1  fetch read request; held high until if_valid.
- if_addr  in  ADDR_W  fetch word address.
- if_rdata  out  DATA_W  fetch read data, registered.
- if_valid  out  1  one-cycle pulse: if_rdata valid, fetch complete.
- d_rd  in  1  data read request; held until d_valid.
- d_wr  in  1  data write request; held until d_valid.
- d_addr  in  ADDR_W  data word address.
- d_wdata  in  DATA_W  store data.
- d_rdata  out  DATA_W  load data, registered.
- d_valid  out  1  one-cycle pulse: load data valid, or write acknowledged.
- mem_en  out  1  RAM enable, registered.
- mem_we  out  1  RAM write enable, registered.
- mem_addr  out  ADDR_W  RAM address, registered.
- mem_wdata  out  DATA_W  RAM write data, registered.
- mem_rdata  in  DATA_W  RAM read data, valid the cycle after mem_en=1, mem_we=0.
- busy  out  1  high whenever FSM is not IDLE.
- proto_err  out  1  sticky: d_rd and d_wr sampled high together.

Behaviour:
- Clock and reset: one clock `clk`; reset is synchronous and active-high. Reset forces the FSM to IDLE, the starve counter to 0, and proto_err to 0. It clears all outputs (if_rdata, d_rdata, if_valid, d_valid, mem_en, mem_we, mem_addr, mem_wdata, busy) to 0.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - Samples requests at each rising edge.
  - Grant selection:
    - fetch wins if starve_cnt == STARVE_LIMIT and if_req;
    - otherwise data wins if d_rd|d_wr;
    - otherwise fetch wins if if_req.
  - On a grant, registers mem_en=1, mem_we (=1 only for a data write), mem_addr, mem_wdata, plus the grant owner, then goes to ISSUE.
  - With no request, it stays in IDLE.
- ISSUE (mem_en high for exactly this one cycle):
  - A read goes to WAIT.
  - A write drops mem_en/mem_we and goes to DONE, asserting d_valid.
- WAIT: captures mem_rdata into if_rdata or d_rdata (by owner) and goes to DONE, asserting the matching valid.
- DONE:
  - The valid pulse is high for this cycle only.
  - Requests sampled in DONE are ignored, so a requester that drops its request after seeing valid is never double-served.
  - Next state is IDLE.
- Latency, with the request sampled at the edge ending cycle N:
  - read: mem_en high in N+1; valid + data in N+3; next grant decision at the edge ending N+4;
  - write: mem_en=mem_we=1 in N+1; d_valid in N+2.
- Starve counter (saturating at STARVE_LIMIT):
  - increments on each IDLE decision granting data while if_req is high;
  - clears on a fetch grant, or on any IDLE edge with if_req low.
- d_rd and d_wr both high at grant: the write is performed, and proto_err is set and held until reset.
- Outputs between accesses:
  - mem_addr/mem_wdata hold their last values; mem_en/mem_we stay 0 outside ISSUE.
  - if_rdata/d_rdata hold their last captured value.
- Reset mid-operation: the FSM returns to IDLE and no valid is generated for the abandoned access. A write already in ISSUE may complete in RAM.
- busy = (state != IDLE), registered.

Test Plan:
- Reset: assert reset 2 cycles with random inputs -> all outputs 0, busy 0, next cycle still idle with no requests.
- Fetch read: RAM[0x010]=0xDEADBEEF, if_req with if_addr=0x010 sampled at end of cycle N -> mem_en=1, mem_we=0, mem_addr=0x010 in N+1; if_valid=1 with if_rdata=0xDEADBEEF in N+3 only.
- Contention: if_req (0x004) and d_rd (0x100) high together, RAM[0x100]=0x0000CAFE -> d_valid with 0x0000CAFE in N+3; fetch granted at the edge ending N+4; if_valid in N+7.
- Store then load: d_wr, d_addr=0x020, d_wdata=0x12345678 -> mem_we=1 in N+1, d_valid in N+2; a following d_rd at 0x020 returns 0x12345678.
- Starvation: if_req held while d_rd re-requests immediately after every d_valid, STARVE_LIMIT=4 -> exactly 4 data grants, then fetch granted on the 5th decision, starve counter back to 0.
- Errors and abort:
  - d_rd=d_wr=1 -> write occurs, proto_err=1 and stays 1.
  - Reset asserted in WAIT of a read -> no if_valid/d_valid, FSM in IDLE, proto_err=0.
